cb: RTL and testbench
=====================

CB -- requirements
Module: cb

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start_count, input, 1 bit: single-cycle pulse marking row 0 of a new 8x8 block on dinre/dinim.
REQ-004 SHALL have port dinre, input, 80 bits: 8 real input lanes, 10-bit two's complement; lane k at bits [10k+9:10k].
REQ-005 SHALL have port dinim, input, 80 bits: 8 imaginary input lanes, same packing as dinre.
REQ-006 SHALL have port doutre, output, 80 bits: 8 real output lanes, same packing.
REQ-007 SHALL have port doutim, output, 80 bits: 8 imaginary output lanes, same packing.
REQ-008 SHALL have port counter, output, 3 bits: index of the column currently on doutre/doutim.
REQ-009 SHALL have port start_send, output, 1 bit: single-cycle pulse marking column 0 on the outputs.

Function
REQ-010 SHALL act as an 8x8 complex corner-turn (transpose) buffer: rows in, columns out.
REQ-011 SHALL implement states IDLE, LOAD and SEND with a 3-bit index register.
REQ-012 In IDLE with start_count=1, SHALL store the din lanes as row 0, set index to 1, and enter LOAD.
REQ-013 In LOAD, SHALL store the din lanes as row index each cycle, with no qualifier; after storing row 7, SHALL set index to 0 and enter SEND.
REQ-014 In SEND, each cycle SHALL register output lane k = element[row k][col index] for re and im, set counter=index, and increment index.
REQ-015 SHALL return from SEND to IDLE after column 7 is registered.
REQ-016 SHALL assert start_send only in the cycle in which column 0 is on the outputs.
REQ-017 Latency: start_count at cycle T (row 0), row 7 at T+7; column 0 with start_send=1 SHALL be visible at T+8 and column 7 at T+15.
REQ-018 SHALL ignore start_count while in LOAD or SEND; no abort and no restart.
REQ-019 SHALL accept a new start_count in the first IDLE cycle after SEND, giving back-to-back blocks every 16 cycles.
REQ-020 SHALL pass data bit-exact, with no arithmetic, scaling or sign change.
REQ-021 Outside SEND, doutre, doutim and counter SHALL hold their last registered values, unless REQ-025 applies.

Reset
REQ-022 With rst_n=0 at a clock edge, SHALL enter IDLE and clear index, counter, start_send, doutre and doutim to 0.
REQ-023 Reset asserted during LOAD or SEND SHALL abort the block; the first start_count after reset SHALL start a clean block.
REQ-024 Buffer storage SHALL NOT require reset.

Configuration
REQ-025 With macro CB_ZERO_IDLE_EN defined, doutre, doutim and counter SHALL be driven to 0 in every cycle not in SEND; without it, REQ-021 applies.

Verification
REQ-026 Transpose: rows r=0..7 with re lane k = 8r+k and im lane k = -(8r+k) -> at T+8+c, re lane k = 8k+c, im lane k = -(8k+c), counter = c.
REQ-027 Handshake: single block -> start_send=1 only at T+8; counter steps 0..7 across T+8..T+15, then holds 7 (or 0 under CB_ZERO_IDLE_EN).
REQ-028 Ignored start: start_count pulses at T+3 and T+10 -> output identical to REQ-026; no second start_send.
REQ-029 Back-to-back: second start_count at T+16 with re lane k = 100+8r+k -> column 0 at T+24 with re lane k = 100+8k.
REQ-030 Reset mid-SEND: rst_n=0 at T+11 -> next cycle all outputs 0 and start_send=0; a fresh block afterwards transposes correctly.
REQ-031 Extremes: all lanes set to -512 and +511 alternately -> values pass through unchanged.

Source files
------------

// File: rtl/cb.sv
// 8x8 complex corner-turn buffer: rows written on dinre/dinim, columns read out on doutre/doutim.
// Optional CB_ZERO_IDLE_EN: outputs and counter forced to 0 whenever not sending.
module cb_row (
    input  logic        clk,
    input  logic        we,
    input  logic [79:0] re_row,
    input  logic [79:0] im_row,
    input  logic [2:0]  col,
    output logic [9:0]  re_sel,
    output logic [9:0]  im_sel
);
    // One buffered row; its column slot feeds output lane equal to the row number.
    logic [7:0][9:0] re_mem;
    logic [7:0][9:0] im_mem;

    always_ff @(posedge clk) begin
        if (we) begin
            re_mem <= re_row;
            im_mem <= im_row;
        end
    end

    assign re_sel = re_mem[col];
    assign im_sel = im_mem[col];
endmodule

module cb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_count,
    input  logic [79:0] dinre,
    input  logic [79:0] dinim,
    output logic [79:0] doutre,
    output logic [79:0] doutim,
    output logic [2:0]  counter,
    output logic        start_send
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            wr_en;
    logic [2:0]      wr_row;
    logic            send_en;
    logic [7:0]      row_we;
    logic [7:0][9:0] sel_re;
    logic [7:0][9:0] sel_im;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_row  = idx_q;
        send_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_count) begin
                    wr_en   = 1'b1;
                    wr_row  = 3'd0;
                    idx_d   = 3'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wr_en = 1'b1;
                if (idx_q == 3'd7) begin
                    idx_d   = 3'd0;
                    state_d = SEND;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SEND: begin
                send_en = 1'b1;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign row_we = wr_en ? (8'd1 << wr_row) : 8'd0;

    for (genvar r = 0; r < 8; r++) begin : g_row
        cb_row u_row (
            .clk    (clk),
            .we     (row_we[r]),
            .re_row (dinre),
            .im_row (dinim),
            .col    (idx_q),
            .re_sel (sel_re[r]),
            .im_sel (sel_im[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            doutre     <= '0;
            doutim     <= '0;
            counter    <= 3'd0;
            start_send <= 1'b0;
        end else if (send_en) begin
            doutre     <= sel_re;
            doutim     <= sel_im;
            counter    <= idx_q;
            start_send <= (idx_q == 3'd0);
        end else begin
            start_send <= 1'b0;
`ifdef CB_ZERO_IDLE_EN
            doutre     <= '0;
            doutim     <= '0;
            counter    <= 3'd0;
`endif
        end
    end
endmodule

// File: tb/tb_cb.sv
// Randomized bench for cb against a block-timing model of the corner turn.
module tb_cb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_count;
    logic [79:0] dinre, dinim, doutre, doutim;
    logic [2:0]  counter;
    logic        start_send;

    int checks = 0;
    int failures = 0;

    // model state
    logic [79:0] mre[8];
    logic [79:0] mim[8];
    logic [79:0] exp_re = '0, exp_im = '0;
    logic [2:0]  exp_cnt = '0;
    logic        exp_ss = 1'b0;
    bit          busy = 1'b0;
    int          t0 = 0;
    int          cyc = 0;

    cb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_count (start_count),
        .dinre       (dinre),
        .dinim       (dinim),
        .doutre      (doutre),
        .doutim      (doutim),
        .counter     (counter),
        .start_send  (start_send)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge, then compare.
    task automatic step(input logic st, input logic rn, input logic [79:0] re, input logic [79:0] im);
        bit was_busy;
        int d;
        start_count = st;
        rst_n = rn;
        dinre = re;
        dinim = im;
        @(posedge clk);
        was_busy = busy;
        if (!rn) begin
            busy = 1'b0;
            exp_re = '0; exp_im = '0; exp_cnt = '0; exp_ss = 1'b0;
        end else begin
            d = cyc - t0;
            if (busy && d >= 1 && d <= 7) begin
                mre[d] = re;
                mim[d] = im;
            end
            if (busy && d >= 8 && d <= 15) begin
                for (int k = 0; k < 8; k++) begin
                    exp_re[10*k +: 10] = mre[k][10*(d-8) +: 10];
                    exp_im[10*k +: 10] = mim[k][10*(d-8) +: 10];
                end
                exp_cnt = 3'(d - 8);
                exp_ss = (d == 8);
                if (d == 15) busy = 1'b0;
            end else begin
                exp_ss = 1'b0;
`ifdef CB_ZERO_IDLE_EN
                exp_re = '0; exp_im = '0; exp_cnt = '0;
`endif
            end
            if (!was_busy && st) begin
                busy = 1'b1;
                t0 = cyc;
                mre[0] = re;
                mim[0] = im;
            end
        end
        cyc++;
        #1;
        chk("doutre", doutre, exp_re);
        chk("doutim", doutim, exp_im);
        chk("counter", 80'(counter), 80'(exp_cnt));
        chk("start_send", 80'(start_send), 80'(exp_ss));
    endtask

    function automatic logic [79:0] rnd80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // mode 0: index pattern (re=base+8r+k, im=-(8r+k)); 1: extremes; 2: random
    task automatic blk(input int mode, input int base, input bit ign, input int rst_at, input int gap);
        logic [79:0] re, im;
        for (int i = 0; i < 16 + gap; i++) begin
            re = rnd80();
            im = rnd80();
            if (i < 8 && mode == 0) begin
                for (int k = 0; k < 8; k++) begin
                    re[10*k +: 10] = 10'(base + 8*i + k);
                    im[10*k +: 10] = 10'(-(8*i + k));
                end
            end else if (i < 8 && mode == 1) begin
                for (int k = 0; k < 8; k++) begin
                    re[10*k +: 10] = ((i + k) % 2 == 1) ? 10'h1FF : 10'h200;
                    im[10*k +: 10] = ((i + k) % 2 == 1) ? 10'h200 : 10'h1FF;
                end
            end
            step((i == 0) || (ign && (i == 3 || i == 10)), (i != rst_at), re, im);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);
        blk(0, 0, 1'b0, -1, 2);          // plain transpose + hold
        blk(0, 0, 1'b1, -1, 0);          // ignored starts, then back-to-back
        blk(0, 100, 1'b0, -1, 1);
        blk(0, 0, 1'b0, 11, 0);          // reset mid-send
        blk(0, 0, 1'b0, -1, 0);          // clean block after reset
        blk(1, 0, 1'b0, -1, 1);          // extremes
        for (int b = 0; b < 8; b++)
            blk(2, 0, 1'($urandom_range(0, 1)), -1, $urandom_range(0, 3));
        for (int i = 0; i < 40; i++)     // random start pulses
            step(1'($urandom_range(0, 3) == 0), 1'b1, rnd80(), rnd80());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
